// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin share of one shift-add multiplier between two requesters.
// Sequences load_a / load_b / start strobes, waits for a fresh done edge, returns the product
// with a one-cycle ack. Optional WAIT watchdog enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_share_arbiter #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned PULSE_CYC   = 1,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic               clk_10kHz,
    input  logic               clrn,
    input  logic               req0,
    input  logic               req1,
    input  logic [WIDTH-1:0]   a0,
    input  logic [WIDTH-1:0]   a1,
    input  logic [WIDTH-1:0]   b0,
    input  logic [WIDTH-1:0]   b1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               ack0,
    output logic               ack1,
    output logic [2*WIDTH-1:0] p0,
    output logic [2*WIDTH-1:0] p1,
    output logic               err0,
    output logic               err1,
    output logic               busy,
    output logic [WIDTH-1:0]   m_a,
    output logic [WIDTH-1:0]   m_b,
    output logic               m_load_a,
    output logic               m_load_b,
    output logic               m_start,
    input  logic               m_done,
    input  logic [2*WIDTH-1:0] m_p
);

    localparam int unsigned CntMax = (PULSE_CYC > TIMEOUT_CYC) ? PULSE_CYC : TIMEOUT_CYC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StStart,
        StWait,
        StCapture
    } state_e;

    state_e               state_q, state_d;
    logic                 owner_q, owner_d;     // 0: requester 0 holds the core
    logic                 rr_q, rr_d;           // last granted requester
    logic [WIDTH-1:0]     m_a_q, m_a_d;
    logic [WIDTH-1:0]     m_b_q, m_b_d;
    logic [2*WIDTH-1:0]   p0_q, p0_d;
    logic [2*WIDTH-1:0]   p1_q, p1_d;
    logic [CntW-1:0]      pulse_cnt_q, pulse_cnt_d;
    logic                 seen_low_q, seen_low_d; // done observed low since START
    logic                 grant;
    logic                 pulse_last;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
    logic [TmoW-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic                 err_q, err_d;
`endif

    // Next-state: arbitration in IDLE, strobe sequencing, done edge detection and capture
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        m_a_d       = m_a_q;
        m_b_d       = m_b_q;
        p0_d        = p0_q;
        p1_d        = p1_q;
        pulse_cnt_d = pulse_cnt_q;
        seen_low_d  = seen_low_q;
        grant       = 1'b0;
        pulse_last  = (pulse_cnt_q == CntW'(PULSE_CYC - 1));
`ifdef MULT_ARB_TIMEOUT_EN
        tmo_cnt_d   = '0;
        err_d       = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    // On a tie the requester that was not served last wins
                    grant       = (req0 && req1) ? ~rr_q : req1;
                    owner_d     = grant;
                    rr_d        = grant;
                    m_a_d       = grant ? a1 : a0;
                    m_b_d       = grant ? b1 : b0;
                    seen_low_d  = 1'b0;
                    pulse_cnt_d = '0;
`ifdef MULT_ARB_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                    state_d     = StLoadA;
                end
            end
            StLoadA: begin
                if (pulse_last) begin
                    pulse_cnt_d = '0;
                    state_d     = StLoadB;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + CntW'(1);
                end
            end
            StLoadB: begin
                if (pulse_last) begin
                    pulse_cnt_d = '0;
                    state_d     = StStart;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + CntW'(1);
                end
            end
            StStart: begin
                if (!m_done) seen_low_d = 1'b1;
                if (pulse_last) begin
                    pulse_cnt_d = '0;
                    state_d     = StWait;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + CntW'(1);
                end
            end
            StWait: begin
                if (!m_done) seen_low_d = 1'b1;
                // Product is captured on entry to CAPTURE so pN is valid alongside ackN
                if (m_done && seen_low_q) begin
                    if (owner_q) p1_d = m_p;
                    else         p0_d = m_p;
                    state_d = StCapture;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1)) begin
                    if (owner_q) p1_d = '0;
                    else         p0_d = '0;
                    err_d   = 1'b1;
                    state_d = StCapture;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                end
`endif
            end
            StCapture: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_10kHz) begin
        if (!clrn) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            rr_q        <= 1'b1;
            m_a_q       <= '0;
            m_b_q       <= '0;
            p0_q        <= '0;
            p1_q        <= '0;
            pulse_cnt_q <= '0;
            seen_low_q  <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            m_a_q       <= m_a_d;
            m_b_q       <= m_b_d;
            p0_q        <= p0_d;
            p1_q        <= p1_d;
            pulse_cnt_q <= pulse_cnt_d;
            seen_low_q  <= seen_low_d;
`ifdef MULT_ARB_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        busy     = (state_q != StIdle);
        gnt0     = busy && !owner_q;
        gnt1     = busy && owner_q;
        ack0     = (state_q == StCapture) && !owner_q;
        ack1     = (state_q == StCapture) && owner_q;
        m_load_a = (state_q == StLoadA);
        m_load_b = (state_q == StLoadB);
        m_start  = (state_q == StStart);
        m_a      = m_a_q;
        m_b      = m_b_q;
        p0       = p0_q;
        p1       = p1_q;
`ifdef MULT_ARB_TIMEOUT_EN
        err0     = ack0 && err_q;
        err1     = ack1 && err_q;
`else
        err0     = 1'b0;
        err1     = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter with a behavioural multiplier core model.
`timescale 1ns/1ps
module tb_mult_share_arbiter;

    localparam int unsigned W  = 8;
    localparam int unsigned PC = 1;
    localparam int unsigned TO = 64;

    logic           clk_10kHz = 1'b0;
    logic           clrn = 1'b0;
    logic           req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0]   a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic           gnt0, gnt1, ack0, ack1, err0, err1, busy;
    logic [2*W-1:0] p0, p1;
    logic [W-1:0]   m_a, m_b;
    logic           m_load_a, m_load_b, m_start;
    logic           m_done = 1'b0;
    logic [2*W-1:0] m_p = '0;

    int checks = 0;
    int failures = 0;

    // Core model controls; manual mode lets a test drive done/product directly
    bit             core_auto = 1'b1;
    int             core_lat = 3;
    logic           man_done = 1'b0;
    logic [2*W-1:0] man_p = '0;

    // Observations gathered by the monitor
    int ack_cnt[2] = '{0, 0};
    int err_cnt = 0;
    int gnt_overlap = 0;
    int strobe_overlap = 0;
    int strobe_log[$];
    int grant_log[$];

    // Round-robin reference: last served requester (1 after reset so requester 0 wins a tie)
    int rr_m = 1;

    mult_share_arbiter #(.WIDTH(W), .PULSE_CYC(PC), .TIMEOUT_CYC(TO)) dut (
        .clk_10kHz(clk_10kHz), .clrn(clrn),
        .req0(req0), .req1(req1), .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .p0(p0), .p1(p1),
        .err0(err0), .err1(err1), .busy(busy), .m_a(m_a), .m_b(m_b),
        .m_load_a(m_load_a), .m_load_b(m_load_b), .m_start(m_start),
        .m_done(m_done), .m_p(m_p)
    );

    always #5 clk_10kHz = ~clk_10kHz;

    function automatic logic [2*W-1:0] prod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] xx, yy;
        xx = {{W{1'b0}}, x};
        yy = {{W{1'b0}}, y};
        return xx * yy;
    endfunction

    // Monitor and multiplier core model, both on the falling edge
    initial begin
        int lat_left;
        logic [W-1:0] ra, rb;
        logic pla, plb, pst, pg0, pg1;
        lat_left = 0; ra = '0; rb = '0;
        pla = 0; plb = 0; pst = 0; pg0 = 0; pg1 = 0;
        forever begin
            @(negedge clk_10kHz);
            if (gnt0 && gnt1) gnt_overlap++;
            if (int'(m_load_a) + int'(m_load_b) + int'(m_start) > 1) strobe_overlap++;
            if (m_load_a && !pla) strobe_log.push_back(0);
            if (m_load_b && !plb) strobe_log.push_back(1);
            if (m_start && !pst) strobe_log.push_back(2);
            if (gnt0 && !pg0) grant_log.push_back(0);
            if (gnt1 && !pg1) grant_log.push_back(1);
            if (ack0) ack_cnt[0]++;
            if (ack1) ack_cnt[1]++;
            if (err0 || err1) err_cnt++;
            pla = m_load_a; plb = m_load_b; pst = m_start; pg0 = gnt0; pg1 = gnt1;
            if (!core_auto) begin
                m_done = man_done;
                m_p    = man_p;
            end else if (!clrn) begin
                lat_left = 0;
                m_done   = 1'b0;
            end else begin
                if (m_load_a) ra = m_a;
                if (m_load_b) rb = m_b;
                if (m_start) begin
                    m_done   = 1'b0;
                    lat_left = core_lat;
                end else if (lat_left > 0) begin
                    lat_left--;
                    if (lat_left == 0) begin
                        m_p    = prod(ra, rb);
                        m_done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        req0 = 1'b0; req1 = 1'b0; clrn = 1'b0;
        repeat (2) @(negedge clk_10kHz);
        clrn = 1'b1;
        @(negedge clk_10kHz);
        rr_m = 1;
    endtask

    task automatic wait_ack(input int bound, output int who, output int cycles);
        who = -1; cycles = 0;
        while (who < 0 && cycles < bound) begin
            @(negedge clk_10kHz);
            cycles++;
            if (ack0) who = 0;
            else if (ack1) who = 1;
        end
    endtask

    task automatic test_reset();
        req0 = 1'b0; req1 = 1'b0; clrn = 1'b0;
        repeat (2) @(negedge clk_10kHz);
        checks++;
        if ({gnt0, gnt1, ack0, ack1, err0, err1, busy, m_load_a, m_load_b, m_start} !== 10'b0 ||
            p0 !== '0 || p1 !== '0 || m_a !== '0 || m_b !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b gnt=%b%b ack=%b%b p0=%0d p1=%0d m_a=%0d, need all 0",
                     busy, gnt0, gnt1, ack0, ack1, p0, p1, m_a);
        end
        clrn = 1'b1;
        repeat (2) @(negedge clk_10kHz);
        checks++;
        if (busy !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0 || m_load_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: busy=%b gnt=%b%b, need idle", busy, gnt0, gnt1);
        end
        rr_m = 1;
    endtask

    task automatic test_single_op();
        for (int i = 0; i < 7; i++) begin
            int who, got, cyc, base;
            logic [W-1:0] a, b;
            logic [2*W-1:0] pv;
            logic gv;
            if (i == 0) begin
                who = 0; a = W'(62); b = W'(3);
            end else begin
                who = int'($urandom_range(0, 1)); a = W'($urandom); b = W'($urandom);
            end
            core_lat = int'($urandom_range(1, 6));
            strobe_log.delete();
            base = ack_cnt[who];
            if (who == 0) begin a0 = a; b0 = b; req0 = 1'b1; end
            else          begin a1 = a; b1 = b; req1 = 1'b1; end
            @(negedge clk_10kHz);
            gv = (who == 0) ? gnt0 : gnt1;
            checks++;
            if (gv !== 1'b1 || m_a !== a || m_b !== b) begin
                failures++;
                $display("FAIL grant_latency op%0d: gnt=%b m_a=%0d m_b=%0d, need gnt=1 m_a=%0d m_b=%0d",
                         i, gv, m_a, m_b, a, b);
            end
            wait_ack(100, got, cyc);
            pv = (who == 0) ? p0 : p1;
            checks++;
            if (got !== who) begin
                failures++;
                $display("FAIL ack_requester op%0d: got %0d, need %0d", i, got, who);
            end
            checks++;
            if (pv !== prod(a, b) || err0 !== 1'b0 || err1 !== 1'b0) begin
                failures++;
                $display("FAIL product op%0d: p=%0d err=%b%b, need p=%0d err=00",
                         i, pv, err0, err1, prod(a, b));
            end
            req0 = 1'b0; req1 = 1'b0;
            repeat (2) @(negedge clk_10kHz);
            checks++;
            if (strobe_log.size() != 3 || strobe_log[0] != 0 || strobe_log[1] != 1 ||
                strobe_log[2] != 2) begin
                failures++;
                $display("FAIL strobe_order op%0d: %0d strobes logged, need load_a,load_b,start",
                         i, strobe_log.size());
            end
            checks++;
            if (ack_cnt[who] - base != 1) begin
                failures++;
                $display("FAIL ack_once op%0d: %0d acks, need 1", i, ack_cnt[who] - base);
            end
            rr_m = who;
        end
    endtask

    task automatic test_contention();
        int exp_who, got, cyc;
        logic [2*W-1:0] pv;
        do_reset();
        core_lat = 4;
        a0 = W'(62); b0 = W'(3); a1 = W'(125); b1 = W'(2);
        req0 = 1'b1; req1 = 1'b1;
        exp_who = (rr_m == 1) ? 0 : 1;
        for (int k = 0; k < 2; k++) begin
            wait_ack(100, got, cyc);
            pv = (exp_who == 0) ? p0 : p1;
            checks++;
            if (got !== exp_who || pv !== ((exp_who == 0) ? prod(a0, b0) : prod(a1, b1))) begin
                failures++;
                $display("FAIL contention_ack%0d: who=%0d p=%0d, need who=%0d p=%0d", k, got, pv,
                         exp_who, (exp_who == 0) ? prod(a0, b0) : prod(a1, b1));
            end
            if (got == 0) req0 = 1'b0;
            if (got == 1) req1 = 1'b0;
            rr_m = exp_who;
            exp_who = 1 - exp_who;
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk_10kHz);
        checks++;
        if (p0 !== 16'd186 || p1 !== 16'd250) begin
            failures++;
            $display("FAIL contention_hold: p0=%0d p1=%0d, need 186 and 250", p0, p1);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ca[2], cb[2];
        int exp_seq[$];
        int exp_who, got, cyc, base0, base1, ov0, sv0;
        logic [2*W-1:0] pv;
        logic gv;
        grant_log.delete();
        base0 = ack_cnt[0]; base1 = ack_cnt[1]; ov0 = gnt_overlap; sv0 = strobe_overlap;
        for (int r = 0; r < 2; r++) begin ca[r] = W'($urandom); cb[r] = W'($urandom); end
        a0 = ca[0]; b0 = cb[0]; a1 = ca[1]; b1 = cb[1];
        req0 = 1'b1; req1 = 1'b1;
        exp_who = (rr_m == 1) ? 0 : 1;
        for (int k = 0; k < 4; k++) begin
            core_lat = int'($urandom_range(1, 5));
            exp_seq.push_back(exp_who);
            wait_ack(100, got, cyc);
            pv = (exp_who == 0) ? p0 : p1;
            checks++;
            if (got !== exp_who || pv !== prod(ca[exp_who], cb[exp_who])) begin
                failures++;
                $display("FAIL fair_op%0d: who=%0d p=%0d, need who=%0d p=%0d", k, got, pv,
                         exp_who, prod(ca[exp_who], cb[exp_who]));
            end
            ca[exp_who] = W'($urandom); cb[exp_who] = W'($urandom);
            a0 = ca[0]; b0 = cb[0]; a1 = ca[1]; b1 = cb[1];
            rr_m = exp_who;
            exp_who = 1 - exp_who;
            if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
            @(negedge clk_10kHz);
            checks++;
            if (busy !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
                failures++;
                $display("FAIL idle_gap%0d: busy=%b gnt=%b%b, need idle", k, busy, gnt0, gnt1);
            end
            if (k < 3) begin
                @(negedge clk_10kHz);
                gv = (exp_who == 0) ? gnt0 : gnt1;
                checks++;
                if (gv !== 1'b1) begin
                    failures++;
                    $display("FAIL regrant%0d: gnt%0d=%b, need 1", k, exp_who, gv);
                end
            end
        end
        repeat (2) @(negedge clk_10kHz);
        checks++;
        if (grant_log.size() != 4 || grant_log[0] != exp_seq[0] || grant_log[1] != exp_seq[1] ||
            grant_log[2] != exp_seq[2] || grant_log[3] != exp_seq[3]) begin
            failures++;
            $display("FAIL grant_sequence: %0d grants logged, need alternating from %0d",
                     grant_log.size(), exp_seq[0]);
        end
        checks++;
        if (ack_cnt[0] - base0 != 2 || ack_cnt[1] - base1 != 2 || gnt_overlap != ov0 ||
            strobe_overlap != sv0) begin
            failures++;
            $display("FAIL fair_counts: acks %0d/%0d overlaps g=%0d s=%0d, need 2/2 and 0 0",
                     ack_cnt[0] - base0, ack_cnt[1] - base1, gnt_overlap - ov0,
                     strobe_overlap - sv0);
        end
    endtask

    task automatic test_stale_done();
        int got, cyc, base;
        do_reset();
        man_done = 1'b1; man_p = 16'hBEEF; core_auto = 1'b0;
        @(negedge clk_10kHz);
        base = ack_cnt[0];
        a0 = W'(10); b0 = W'(20); req0 = 1'b1;
        repeat (20) @(negedge clk_10kHz);
        checks++;
        if (ack_cnt[0] != base || busy !== 1'b1) begin
            failures++;
            $display("FAIL stale_done_ignored: acks=%0d busy=%b, need 0 acks busy=1",
                     ack_cnt[0] - base, busy);
        end
        man_done = 1'b0; man_p = 16'd200;
        repeat (3) @(negedge clk_10kHz);
        man_done = 1'b1;
        wait_ack(10, got, cyc);
        checks++;
        if (got !== 0 || p0 !== 16'd200) begin
            failures++;
            $display("FAIL stale_done_fresh_edge: who=%0d p0=%0d, need who=0 p0=200", got, p0);
        end
        req0 = 1'b0;
        core_auto = 1'b1;
        repeat (2) @(negedge clk_10kHz);
        rr_m = 0;
    endtask

    task automatic test_reset_mid_wait();
        int got, cyc, base;
        do_reset();
        core_lat = 100000;
        a0 = W'($urandom); b0 = W'($urandom); req0 = 1'b1;
        repeat (8) @(negedge clk_10kHz);
        base = ack_cnt[0];
        clrn = 1'b0;
        @(negedge clk_10kHz);
        checks++;
        if (busy !== 1'b0 || gnt0 !== 1'b0 || ack0 !== 1'b0 || m_start !== 1'b0 ||
            m_load_a !== 1'b0 || m_load_b !== 1'b0 || m_a !== '0 || p0 !== '0) begin
            failures++;
            $display("FAIL reset_abort: busy=%b gnt0=%b ack0=%b m_a=%0d, need all 0",
                     busy, gnt0, ack0, m_a);
        end
        @(negedge clk_10kHz);
        req0 = 1'b0; clrn = 1'b1;
        repeat (2) @(negedge clk_10kHz);
        checks++;
        if (ack_cnt[0] != base || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_ack: acks=%0d busy=%b, need 0 acks idle", ack_cnt[0] - base, busy);
        end
        rr_m = 1;
        a0 = W'($urandom_range(1, 255)); b0 = W'($urandom_range(1, 255)); req0 = 1'b1;
`ifdef MULT_ARB_TIMEOUT_EN
        wait_ack(TO + 3 * PC + 20, got, cyc);
        checks++;
        if (got !== 0 || cyc != TO + 3 * PC + 1) begin
            failures++;
            $display("FAIL timeout_latency: who=%0d cycles=%0d, need who=0 cycles=%0d", got, cyc,
                     TO + 3 * PC + 1);
        end
        checks++;
        if (err0 !== 1'b1 || ack0 !== 1'b1 || p0 !== '0) begin
            failures++;
            $display("FAIL timeout_err: err0=%b ack0=%b p0=%0d, need 1 1 0", err0, ack0, p0);
        end
`else
        wait_ack(200, got, cyc);
        checks++;
        if (got !== -1 || err_cnt != 0) begin
            failures++;
            $display("FAIL wait_forever: who=%0d errs=%0d, need no ack and no err", got, err_cnt);
        end
`endif
        do_reset();
        core_lat = 3;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d",
                 checks, failures);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_back_to_back();
        test_stale_done();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
